// File: rtl/mor1kx_trace_packetizer.sv
// Instruction-trace packetizer: buffers retired-instruction events in a small FIFO
// and serializes them as 16-bit flits, with an overflow packet reporting dropped events.
module mor1kx_trace_packetizer #(
  parameter int unsigned ID    = 0,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trace_enable_i,
  input  logic        trace_valid_i,
  input  logic [31:0] trace_pc_i,
  input  logic        trace_jb_i,
  input  logic        trace_wben_i,
  input  logic [4:0]  trace_wbreg_i,
  input  logic [31:0] trace_wbdata_i,
  output logic        out_valid_o,
  output logic [15:0] out_data_o,
  output logic        out_last_o,
  input  logic        out_ready_i
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [5:0]  ID6   = 6'(ID);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        jb;
    logic        wben;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC_LO, S_PC_HI, S_DAT_LO, S_DAT_HI, S_OVF_HDR, S_OVF_CNT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]     drop_q, drop_d;
  entry_t          mem_q [DEPTH];
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  entry_t in_entry_c;
  entry_t head_c;
  logic   push_c;
  logic   drop_c;
  logic   hs_c;
  logic   pop_c;

  assign in_entry_c = '{pc: trace_pc_i, jb: trace_jb_i, wben: trace_wben_i,
                        wbreg: trace_wbreg_i, wbdata: trace_wbdata_i};
  assign push_c = trace_valid_i & trace_enable_i & (count_q != FULL);
  assign drop_c = trace_valid_i & trace_enable_i & (count_q == FULL);
  assign hs_c   = out_valid_q & out_ready_i;
  assign pop_c  = hs_c & out_last_q & (state_q != S_OVF_CNT);
  // An empty FIFO forwards the incoming event so its header can issue next cycle.
  assign head_c = (count_q == '0) ? in_entry_c : mem_q[rd_ptr_q];

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (drop_q != 16'h0000) begin
          state_d = S_OVF_HDR;
        end else if ((count_q != '0) || push_c) begin
          state_d = S_HDR;
        end
      end
      S_HDR:     if (hs_c) state_d = S_PC_LO;
      S_PC_LO:   if (hs_c) state_d = S_PC_HI;
      S_PC_HI:   if (hs_c) state_d = head_c.wben ? S_DAT_LO : S_IDLE;
      S_DAT_LO:  if (hs_c) state_d = S_DAT_HI;
      S_DAT_HI:  if (hs_c) state_d = S_IDLE;
      S_OVF_HDR: if (hs_c) state_d = S_OVF_CNT;
      S_OVF_CNT: if (hs_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Flit registers are loaded for the state being entered and frozen while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (!(out_valid_q && !out_ready_i)) begin
      out_valid_d = (state_d != S_IDLE);
      out_data_d  = 16'h0000;
      out_last_d  = 1'b0;
      unique case (state_d)
        S_IDLE: ;
        S_HDR: begin
          out_data_d = {(head_c.wben ? 4'h2 : 4'h1), head_c.jb,
                        (head_c.wben ? head_c.wbreg : 5'd0), ID6};
        end
        S_PC_LO: out_data_d = head_c.pc[15:0];
        S_PC_HI: begin
          out_data_d = head_c.pc[31:16];
          out_last_d = ~head_c.wben;
        end
        S_DAT_LO: out_data_d = head_c.wbdata[15:0];
        S_DAT_HI: begin
          out_data_d = head_c.wbdata[31:16];
          out_last_d = 1'b1;
        end
        S_OVF_HDR: out_data_d = {4'hF, 6'h00, ID6};
        S_OVF_CNT: begin
          out_data_d = drop_d;
          out_last_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // Drops that coincide with the overflow report are carried into the next report.
  always_comb begin
    drop_d = drop_q;
    if ((state_q == S_OVF_CNT) && hs_c) begin
      drop_d = drop_c ? 16'h0001 : 16'h0000;
    end else if (drop_c && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_last_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= in_entry_c;
  end

endmodule

// File: tb/tb_mor1kx_trace_packetizer.sv
// Scoreboard bench for mor1kx_trace_packetizer: expected flits are queued at stimulus
// time and a forked monitor compares every accepted flit, hold stability and packet gaps.
module tb_mor1kx_trace_packetizer;

  localparam int unsigned TB_ID    = 3;
  localparam int unsigned TB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_enable = 1'b1;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = '0;
  logic        trace_jb = 1'b0;
  logic        trace_wben = 1'b0;
  logic [4:0]  trace_wbreg = '0;
  logic [31:0] trace_wbdata = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;

  logic [16:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          gap = 0;
  logic        backlog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_flit = '0;
  logic        toggle_ready = 1'b0;

  always #5 clk = ~clk;

  mor1kx_trace_packetizer #(.ID(TB_ID), .DEPTH(TB_DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trace_enable_i (trace_enable),
    .trace_valid_i  (trace_valid),
    .trace_pc_i     (trace_pc),
    .trace_jb_i     (trace_jb),
    .trace_wben_i   (trace_wben),
    .trace_wbreg_i  (trace_wbreg),
    .trace_wbdata_i (trace_wbdata),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_last_o     (out_last),
    .out_ready_i    (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic jb, input logic wben,
                      input logic [4:0] wreg, input logic [31:0] wdat);
    trace_valid  = 1'b1;
    trace_pc     = pc;
    trace_jb     = jb;
    trace_wben   = wben;
    trace_wbreg  = wreg;
    trace_wbdata = wdat;
    tick();
    trace_valid  = 1'b0;
  endtask

  // Reference flit encoding of one exec packet.
  task automatic push_pkt(input logic [31:0] pc, input logic jb, input logic wben,
                          input logic [4:0] wreg, input logic [31:0] wdat);
    logic [15:0] hdr;
    hdr = {(wben ? 4'h2 : 4'h1), jb, (wben ? wreg : 5'd0), 6'(TB_ID)};
    exp_q.push_back({1'b0, hdr});
    exp_q.push_back({1'b0, pc[15:0]});
    exp_q.push_back({~wben, pc[31:16]});
    if (wben) begin
      exp_q.push_back({1'b0, wdat[15:0]});
      exp_q.push_back({1'b1, wdat[31:16]});
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      if (toggle_ready) out_ready = ~out_ready;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d flits still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    repeat (5) tick();
  endtask

  task automatic monitor();
    logic [16:0] flit;
    logic [16:0] exp;
    forever begin
      @(negedge clk);
      flit = {out_last, out_data};
      if (!rst_n) begin
        prev_stall = 1'b0;
        gap        = 0;
      end else begin
        if (gap == 1) begin
          tests++;
          if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL gap_idle: out_valid=%b, required 0", out_valid);
          end
          gap = 2;
        end else if (gap == 2) begin
          if (backlog) begin
            tests++;
            if (out_valid !== 1'b1) begin
              fails++;
              $display("FAIL gap_next: out_valid=%b, required 1", out_valid);
            end
          end
          gap = 0;
        end
        if (prev_stall && out_valid) begin
          tests++;
          if (flit !== prev_flit) begin
            fails++;
            $display("FAIL stall_hold: got last=%b data=0x%h, required last=%b data=0x%h",
                     flit[16], flit[15:0], prev_flit[16], prev_flit[15:0]);
          end
        end
        if (out_valid && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_flit: got last=%b data=0x%h, required no flit",
                     flit[16], flit[15:0]);
          end else begin
            exp = exp_q.pop_front();
            if (flit !== exp) begin
              fails++;
              $display("FAIL flit: got last=%b data=0x%h, required last=%b data=0x%h",
                       flit[16], flit[15:0], exp[16], exp[15:0]);
            end
            if (exp[16]) begin
              gap     = 1;
              backlog = (exp_q.size() != 0);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_flit  = flit;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single exec packet without writeback, header one cycle after the push
    exp_q.push_back(17'h0_1803);
    exp_q.push_back(17'h0_1234);
    exp_q.push_back(17'h1_0000);
    send(32'h0000_1234, 1'b1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'h1);
    chk("latency_hdr", 32'(out_data), 32'h1803);
    wait_drain("nowb");
    chk("nowb_fifo_empty", 32'(dut.count_q), 32'h0);

    // Exec packet with writeback (ID=3 in the header)
    exp_q.push_back(17'h0_2143);
    exp_q.push_back(17'h0_0010);
    exp_q.push_back(17'h0_8000);
    exp_q.push_back(17'h0_BEEF);
    exp_q.push_back(17'h1_DEAD);
    send(32'h8000_0010, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    wait_drain("wb");

    // Ready toggling every cycle across a 5-flit packet
    exp_q.push_back(17'h0_2FC3);
    exp_q.push_back(17'h0_0ABC);
    exp_q.push_back(17'h0_4000);
    exp_q.push_back(17'h0_9BDF);
    exp_q.push_back(17'h1_1357);
    out_ready = 1'b0;
    toggle_ready = 1'b1;
    send(32'h4000_0ABC, 1'b1, 1'b1, 5'd31, 32'h1357_9BDF);
    wait_drain("toggle");

    // Seven events into a stalled 4-deep FIFO: event 0 is already in flight,
    // so the overflow report follows it, ahead of the remaining stored events.
    out_ready = 1'b0;
    push_pkt(32'h0001_0000, 1'b0, 1'b0, 5'd8, 32'hCAFE_0000);
    exp_q.push_back(17'h0_F003);
    exp_q.push_back(17'h1_0003);
    push_pkt(32'h0001_0010, 1'b0, 1'b1, 5'd9, 32'hCAFE_0001);
    push_pkt(32'h0001_0020, 1'b1, 1'b0, 5'd10, 32'hCAFE_0002);
    push_pkt(32'h0001_0030, 1'b0, 1'b1, 5'd11, 32'hCAFE_0003);
    for (int i = 0; i < 7; i++) begin
      send(32'h0001_0000 + 32'(i * 16), (i == 2), i[0], 5'(i + 8), 32'hCAFE_0000 | 32'(i));
    end
    tick();
    chk("ovf_fifo_full", 32'(dut.count_q), 32'd4);
    out_ready = 1'b1;
    wait_drain("overflow");

    // Events while disabled are neither stored nor counted as drops
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_pkt(32'h2000_0000 + 32'(i * 256), i[1], i[0], 5'(i + 1), 32'h5A5A_0000 + 32'(i));
      send(32'h2000_0000 + 32'(i * 256), i[1], i[0], 5'(i + 1), 32'h5A5A_0000 + 32'(i));
    end
    trace_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(32'h3000_0000 + 32'(i), 1'b0, 1'b0, 5'd0, 32'h0);
    end
    trace_enable = 1'b1;
    chk("dis_fifo_count", 32'(dut.count_q), 32'd4);
    chk("dis_drop_count", 32'(dut.drop_q), 32'd0);
    out_ready = 1'b1;
    wait_drain("disabled");

    // Reset pulse during PC_LO aborts the packet and discards the FIFO
    out_ready = 1'b0;
    exp_q.push_back(17'h0_2083);
    send(32'h0000_5678, 1'b0, 1'b1, 5'd2, 32'h1111_2222);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_pc_lo", 32'(out_data), 32'h5678);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_valid", 32'(out_valid), 32'h0);
    chk("rstmid_async_data", 32'(out_data), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rstmid_quiet", 32'(out_valid), 32'h0);
    push_pkt(32'h0BAD_F00D, 1'b1, 1'b0, 5'd0, 32'h0);
    send(32'h0BAD_F00D, 1'b1, 1'b0, 5'd0, 32'h0);
    wait_drain("after_rst");
    chk("final_fifo_empty", 32'(dut.count_q), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
